// File: rtl/link_dir_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : link_dir_sched_if
// Purpose  : Handshake, link-monitor and status bundle of link_dir_sched.
// Revision : 1.0
// ============================================================================
interface link_dir_sched_if;
   logic       start;
   logic       S1_done;
   logic       S2_done;
   logic       sen;
   logic       sd;
   logic       updown;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] err_code;
   logic [3:0] frame_cnt;
   logic [3:0] round_cnt;

   modport master (
      output start, S1_done, S2_done, sen, sd,
      input  updown, busy, done, err, err_code, frame_cnt, round_cnt
   );

   modport slave (
      input  start, S1_done, S2_done, sen, sd,
      output updown, busy, done, err, err_code, frame_cnt, round_cnt
   );
endinterface
`default_nettype wire

// File: rtl/link_dir_sched.sv
`default_nettype none
// ============================================================================
// Module   : link_dir_sched
// Purpose  : Runs down/up burst rounds on the sen/sd link and checks frames.
// Revision : 1.0
// ============================================================================
module link_dir_sched #(
   parameter int ROUNDS  = 1,
   parameter int GAP_CYC = 4,
   parameter int TIMEOUT = 64
) (
   input  wire logic       clk,
   input  wire logic       rst,
   link_dir_sched_if.slave bus
);

   localparam int c_TW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DOWN  = 3'd1,
      S_GAP_U = 3'd2,
      S_UP    = 3'd3,
      S_GAP_D = 3'd4,
      S_DONE  = 3'd5,
      S_ERR   = 3'd6
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_frame_cnt;
   logic [3:0]        r_round_cnt;
   logic [2:0]        r_exp_addr;
   logic [20:0]       r_shift;
   logic [4:0]        r_low_cnt;
   logic [c_TW-1:0]   r_tmo_cnt;
   logic [3:0]        r_gap_cnt;
   logic              r_err;
   logic [1:0]        r_err_code;

   logic              w_mon_act;
   logic              w_in_gap;
   logic              w_strobe;
   logic              w_tmo;
   logic              w_gap_done;
   logic              w_bad_len;
   logic              w_bad_addr;
   logic              w_start_acc;
   logic              w_burst_init;
   logic              w_frame_ok;
   logic              w_round_inc;
   logic              w_go_err;
   logic [1:0]        w_code_nxt;

   assign w_mon_act  = (r_state == S_DOWN) || (r_state == S_UP);
   assign w_in_gap   = (r_state == S_GAP_U) || (r_state == S_GAP_D);
   // A non-zero low count means the previous monitored cycle had sen=0.
   assign w_strobe   = w_mon_act && bus.sen && (r_low_cnt != 5'd0);
   assign w_tmo      = w_mon_act && (r_tmo_cnt == c_TW'(TIMEOUT - 1));
   assign w_gap_done = (r_gap_cnt == 4'(GAP_CYC - 1));
   assign w_bad_len  = (r_low_cnt != 5'd21);
   assign w_bad_addr = (r_shift[20:18] != r_exp_addr) || (r_frame_cnt == 4'd8);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_start_acc  = 1'b0;
      w_burst_init = 1'b0;
      w_frame_ok   = 1'b0;
      w_round_inc  = 1'b0;
      w_go_err     = 1'b0;
      w_code_nxt   = 2'd0;
      case (r_state)
         S_IDLE, S_ERR: begin
            if (bus.start) begin
               w_state_nxt  = S_DOWN;
               w_start_acc  = 1'b1;
               w_burst_init = 1'b1;
            end
         end
         S_DOWN, S_UP: begin
            if (w_tmo) begin
               w_state_nxt = S_ERR;
               w_go_err    = 1'b1;
               w_code_nxt  = 2'd1;
            end else if (w_strobe && w_bad_len) begin
               w_state_nxt = S_ERR;
               w_go_err    = 1'b1;
               w_code_nxt  = 2'd2;
            end else if (w_strobe && w_bad_addr) begin
               w_state_nxt = S_ERR;
               w_go_err    = 1'b1;
               w_code_nxt  = 2'd3;
            end else if (w_strobe) begin
               w_frame_ok = 1'b1;
            end else if (r_frame_cnt == 4'd8) begin
               if ((r_state == S_DOWN) && bus.S2_done) begin
                  w_state_nxt = S_GAP_U;
               end else if ((r_state == S_UP) && bus.S1_done) begin
                  w_state_nxt = S_GAP_D;
                  w_round_inc = 1'b1;
               end
            end
         end
         S_GAP_U: begin
            if (w_gap_done) begin
               w_state_nxt  = S_UP;
               w_burst_init = 1'b1;
            end
         end
         S_GAP_D: begin
            if (w_gap_done) begin
               if (r_round_cnt == 4'(ROUNDS)) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt  = S_DOWN;
                  w_burst_init = 1'b1;
               end
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_cnt <= 4'd0;
         r_round_cnt <= 4'd0;
         r_exp_addr  <= 3'd7;
         r_shift     <= 21'd0;
         r_low_cnt   <= 5'd0;
         r_tmo_cnt   <= '0;
         r_gap_cnt   <= 4'd0;
         r_err       <= 1'b0;
         r_err_code  <= 2'd0;
      end else begin
         if (w_burst_init) begin
            r_frame_cnt <= 4'd0;
            r_exp_addr  <= 3'd7;
         end else if (w_frame_ok) begin
            r_frame_cnt <= r_frame_cnt + 4'd1;
            r_exp_addr  <= r_exp_addr - 3'd1;
         end

         if (w_start_acc)      r_round_cnt <= 4'd0;
         else if (w_round_inc) r_round_cnt <= r_round_cnt + 4'd1;

         if (w_start_acc) begin
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
         end else if (w_go_err) begin
            r_err      <= 1'b1;
            r_err_code <= w_code_nxt;
         end

         if (w_in_gap && !w_gap_done) r_gap_cnt <= r_gap_cnt + 4'd1;
         else                         r_gap_cnt <= 4'd0;

         if (!w_mon_act || w_strobe) r_tmo_cnt <= '0;
         else                        r_tmo_cnt <= r_tmo_cnt + 1'b1;

         if (!w_mon_act || w_strobe) begin
            r_low_cnt <= 5'd0;
            r_shift   <= 21'd0;
         end else if (!bus.sen) begin
            if (r_low_cnt != 5'd31) r_low_cnt <= r_low_cnt + 5'd1;
            r_shift <= {r_shift[19:0], bus.sd};
         end
      end
   end

   assign bus.updown    = !((r_state == S_GAP_U) || (r_state == S_UP));
   assign bus.busy      = w_mon_act || w_in_gap;
   assign bus.done      = (r_state == S_DONE);
   assign bus.err       = r_err;
   assign bus.err_code  = r_err_code;
   assign bus.frame_cnt = r_frame_cnt;
   assign bus.round_cnt = r_round_cnt;

endmodule
`default_nettype wire

// File: tb/tb_link_dir_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_link_dir_sched
// Purpose  : Directed bench for link_dir_sched (ROUNDS=1 and ROUNDS=3 copies).
// Revision : 1.0
// ============================================================================
module tb_link_dir_sched;
   localparam int GAP = 4;
   localparam int TMO = 64;

   logic clk = 1'b0;
   logic rst;
   logic start, s1d, s2d, sen, sd;
   logic mon_clr;
   int   errors = 0;
   int   checks = 0;
   int   toggles, pulses;
   logic prev_ud;

   link_dir_sched_if if_a ();
   link_dir_sched_if if_b ();

   assign if_a.start = start;  assign if_b.start = start;
   assign if_a.S1_done = s1d;  assign if_b.S1_done = s1d;
   assign if_a.S2_done = s2d;  assign if_b.S2_done = s2d;
   assign if_a.sen = sen;      assign if_b.sen = sen;
   assign if_a.sd = sd;        assign if_b.sd = sd;

   link_dir_sched #(.ROUNDS(1), .GAP_CYC(GAP), .TIMEOUT(TMO)) u_dut_a (
      .clk(clk), .rst(rst), .bus(if_a));
   link_dir_sched #(.ROUNDS(3), .GAP_CYC(GAP), .TIMEOUT(TMO)) u_dut_b (
      .clk(clk), .rst(rst), .bus(if_b));

   always #5 clk = ~clk;

   // updown toggles and done pulses of the ROUNDS=3 copy
   always @(negedge clk) begin
      prev_ud <= if_b.updown;
      if (mon_clr) begin
         toggles <= 0;
         pulses  <= 0;
      end else begin
         if (if_b.updown !== prev_ud) toggles <= toggles + 1;
         if (if_b.done === 1'b1)      pulses  <= pulses + 1;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; s1d = 1'b0; s2d = 1'b0; sen = 1'b1; sd = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic send_frame(input logic [2:0] a, input logic [17:0] d, input int len);
      logic [20:0] w;
      w = {a, d};
      for (int i = 0; i < len; i++) begin
         tick();
         sen = 1'b0;
         sd  = (i < 21) ? w[20 - i] : 1'b0;
      end
      tick();
      sen = 1'b1; sd = 1'b0;
   endtask

   task automatic send_burst();
      for (int k = 7; k >= 0; k--) send_frame(3'(k), 18'(k * 4097 + 5), 21);
      tick();
   endtask

   task automatic clean_round();
      send_burst(); s2d = 1'b1; tick(); s2d = 1'b0;
      repeat (GAP) tick();
      send_burst(); s1d = 1'b1; tick(); s1d = 1'b0;
      repeat (GAP) tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (if_a.updown !== 1'b1) begin errors++; $display("FAIL rst_updown: got %0d expected 1", if_a.updown); end
      checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0d expected 0", if_a.busy); end
      checks++; if (if_a.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0d expected 0", if_a.done); end
      checks++; if (if_a.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0d expected 0", if_a.err); end
      checks++; if (if_a.err_code !== 2'd0) begin errors++; $display("FAIL rst_code: got %0d expected 0", if_a.err_code); end
      checks++; if (if_a.frame_cnt !== 4'd0) begin errors++; $display("FAIL rst_frame: got %0d expected 0", if_a.frame_cnt); end
      checks++; if (if_a.round_cnt !== 4'd0) begin errors++; $display("FAIL rst_round: got %0d expected 0", if_a.round_cnt); end
   endtask

   task automatic test_single_round();
      do_reset();
      pulse_start();
      checks++; if (if_a.busy !== 1'b1) begin errors++; $display("FAIL one_busy: got %0d expected 1", if_a.busy); end
      send_burst();
      checks++; if (if_a.frame_cnt !== 4'd8) begin errors++; $display("FAIL one_down_frames: got %0d expected 8", if_a.frame_cnt); end
      checks++; if (if_a.updown !== 1'b1) begin errors++; $display("FAIL one_down_ud: got %0d expected 1", if_a.updown); end
      s2d = 1'b1; tick(); s2d = 1'b0;
      checks++; if (if_a.updown !== 1'b0) begin errors++; $display("FAIL one_gapu_ud: got %0d expected 0", if_a.updown); end
      start = 1'b1; tick(); start = 1'b0;
      checks++; if (if_a.frame_cnt !== 4'd8 || if_a.updown !== 1'b0) begin errors++; $display("FAIL one_start_ignored: frame %0d ud %0d expected 8 0", if_a.frame_cnt, if_a.updown); end
      repeat (GAP - 1) tick();
      checks++; if (if_a.frame_cnt !== 4'd0 || if_a.updown !== 1'b0) begin errors++; $display("FAIL one_up_entry: frame %0d ud %0d expected 0 0", if_a.frame_cnt, if_a.updown); end
      send_burst();
      checks++; if (if_a.frame_cnt !== 4'd8) begin errors++; $display("FAIL one_up_frames: got %0d expected 8", if_a.frame_cnt); end
      s1d = 1'b1; tick(); s1d = 1'b0;
      checks++; if (if_a.updown !== 1'b1 || if_a.round_cnt !== 4'd1) begin errors++; $display("FAIL one_gapd: ud %0d round %0d expected 1 1", if_a.updown, if_a.round_cnt); end
      repeat (GAP) tick();
      checks++; if (if_a.done !== 1'b1 || if_a.busy !== 1'b0) begin errors++; $display("FAIL one_done: done %0d busy %0d expected 1 0", if_a.done, if_a.busy); end
      tick();
      checks++; if (if_a.done !== 1'b0 || if_a.err !== 1'b0) begin errors++; $display("FAIL one_after_done: done %0d err %0d expected 0 0", if_a.done, if_a.err); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      mon_clr = 1'b1; tick(); mon_clr = 1'b0;
      s1d = 1'b1; s2d = 1'b1;
      pulse_start();
      for (int r = 0; r < 3; r++) begin
         send_burst(); tick(); repeat (GAP) tick();
         send_burst(); tick(); repeat (GAP) tick();
      end
      checks++; if (if_b.done !== 1'b1 || if_b.round_cnt !== 4'd3) begin errors++; $display("FAIL b2b_done: done %0d round %0d expected 1 3", if_b.done, if_b.round_cnt); end
      tick();
      s1d = 1'b0; s2d = 1'b0;
      checks++; if (toggles !== 6) begin errors++; $display("FAIL b2b_toggles: got %0d expected 6", toggles); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL b2b_pulses: got %0d expected 1", pulses); end
      checks++; if (if_b.busy !== 1'b0 || if_b.err !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy %0d err %0d expected 0 0", if_b.busy, if_b.err); end
   endtask

   task automatic test_bad_length();
      do_reset();
      pulse_start();
      send_frame(3'd7, 18'h2A5A5, 20);
      tick();
      checks++; if (if_a.err !== 1'b1 || if_a.err_code !== 2'd2) begin errors++; $display("FAIL len_err: err %0d code %0d expected 1 2", if_a.err, if_a.err_code); end
      checks++; if (if_a.updown !== 1'b1 || if_a.busy !== 1'b0) begin errors++; $display("FAIL len_state: ud %0d busy %0d expected 1 0", if_a.updown, if_a.busy); end
      pulse_start();
      checks++; if (if_a.err !== 1'b0 || if_a.err_code !== 2'd0 || if_a.busy !== 1'b1) begin errors++; $display("FAIL len_restart: err %0d code %0d busy %0d expected 0 0 1", if_a.err, if_a.err_code, if_a.busy); end
      clean_round();
      checks++; if (if_a.done !== 1'b1 || if_a.err !== 1'b0) begin errors++; $display("FAIL len_recover: done %0d err %0d expected 1 0", if_a.done, if_a.err); end
   endtask

   task automatic test_addr_order();
      do_reset();
      pulse_start();
      send_frame(3'd7, 18'h00011, 21);
      send_frame(3'd6, 18'h3FFFF, 21);
      send_frame(3'd4, 18'h12345, 21);
      tick();
      checks++; if (if_a.err !== 1'b1 || if_a.err_code !== 2'd3) begin errors++; $display("FAIL addr_err: err %0d code %0d expected 1 3", if_a.err, if_a.err_code); end
      checks++; if (if_a.frame_cnt !== 4'd2) begin errors++; $display("FAIL addr_frames: got %0d expected 2", if_a.frame_cnt); end
   endtask

   task automatic test_ninth_frame();
      do_reset();
      pulse_start();
      send_burst();
      send_frame(3'd7, 18'h0ABCD, 21);
      tick();
      checks++; if (if_a.err !== 1'b1 || if_a.err_code !== 2'd3 || if_a.frame_cnt !== 4'd8) begin errors++; $display("FAIL ninth: err %0d code %0d frame %0d expected 1 3 8", if_a.err, if_a.err_code, if_a.frame_cnt); end
   endtask

   task automatic test_timeout();
      do_reset();
      pulse_start();
      send_burst(); s2d = 1'b1; tick(); s2d = 1'b0;
      repeat (GAP) tick();
      send_frame(3'd7, 18'h1, 21);
      send_frame(3'd6, 18'h2, 21);
      send_frame(3'd5, 18'h3, 21);
      tick();
      repeat (TMO - 1) tick();
      checks++; if (if_a.err !== 1'b0 || if_a.updown !== 1'b0) begin errors++; $display("FAIL tmo_early: err %0d ud %0d expected 0 0", if_a.err, if_a.updown); end
      tick();
      checks++; if (if_a.err !== 1'b1 || if_a.err_code !== 2'd1) begin errors++; $display("FAIL tmo_err: err %0d code %0d expected 1 1", if_a.err, if_a.err_code); end
      checks++; if (if_a.updown !== 1'b1 || if_a.busy !== 1'b0) begin errors++; $display("FAIL tmo_state: ud %0d busy %0d expected 1 0", if_a.updown, if_a.busy); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      pulse_start();
      send_burst(); s2d = 1'b1; tick(); s2d = 1'b0;
      repeat (GAP) tick();
      for (int k = 7; k >= 4; k--) send_frame(3'(k), 18'(k), 21);
      for (int i = 0; i < 10; i++) begin
         tick(); sen = 1'b0; sd = i[0];
      end
      rst = 1'b1; tick();
      checks++; if (if_a.updown !== 1'b1 || if_a.busy !== 1'b0 || if_a.done !== 1'b0 || if_a.err !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: ud %0d busy %0d done %0d err %0d expected 1 0 0 0", if_a.updown, if_a.busy, if_a.done, if_a.err); end
      checks++; if (if_a.err_code !== 2'd0 || if_a.frame_cnt !== 4'd0 || if_a.round_cnt !== 4'd0) begin errors++; $display("FAIL mid_rst_cnts: code %0d frame %0d round %0d expected 0 0 0", if_a.err_code, if_a.frame_cnt, if_a.round_cnt); end
      rst = 1'b0; sen = 1'b1; sd = 1'b0;
      pulse_start();
      clean_round();
      checks++; if (if_a.done !== 1'b1 || if_a.round_cnt !== 4'd1 || if_a.err !== 1'b0) begin errors++; $display("FAIL mid_rst_rerun: done %0d round %0d err %0d expected 1 1 0", if_a.done, if_a.round_cnt, if_a.err); end
   endtask

   initial begin
      mon_clr = 1'b0;
      test_reset();
      test_single_round();
      test_back_to_back();
      test_bad_length();
      test_addr_order();
      test_ninth_frame();
      test_timeout();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
